// File: rtl/hht_row_mac.sv
// hht_row_mac: per-row multiply-accumulate behind the HHT gather stage.
// Ports:
//   Clk, Rst (async active-low)
//   start/num_rows      begin a pass of num_rows rows
//   len_*               per-row nonzero count stream (valid/ready)
//   in_*                matrix/vector operand pairs (valid/ready)
//   out_*               row dot product + row index (valid/ready)
//   busy, done          pass status; done pulses after the last result

module hht_row_mac #(
    parameter int DW = 32,
    parameter int AW = 64,
    parameter int RW = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic [RW-1:0] num_rows,
    input  logic          len_valid,
    output logic          len_ready,
    input  logic [31:0]   len_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_mval,
    input  logic [DW-1:0] in_vval,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic [RW-1:0] out_row,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        GETLEN,
        ACCUM,
        EMIT
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [31:0]     remaining;
    logic [RW-1:0]   rows_left;
    logic [RW-1:0]   row_idx;

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_next;

    // Full-width product, then resized to the accumulator: zero-extended
    // when AW is wider, truncated (modulo 2^AW) when narrower.
    assign prod     = (2*DW)'(in_mval) * (2*DW)'(in_vval);
    assign acc_next = acc + AW'(prod);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            rows_left <= '0;
            row_idx   <= '0;
            len_ready <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            rows_left <= num_rows;
                            row_idx   <= '0;
                            busy      <= 1'b1;
                            len_ready <= 1'b1;
                            state     <= GETLEN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                GETLEN: begin
                    if (len_valid && len_ready) begin
                        remaining <= len_data;
                        acc       <= '0;
                        len_ready <= 1'b0;
                        if (len_data == 32'd0) begin
                            // Empty row: emit a zero result directly.
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_row   <= row_idx;
                            state     <= EMIT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc       <= acc_next;
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                            out_row   <= row_idx;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        row_idx   <= row_idx + RW'(1);
                        rows_left <= rows_left - RW'(1);
                        if (rows_left == RW'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            len_ready <= 1'b1;
                            state     <= GETLEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
